dbus_mmio_bridge: RTL and testbench

- Data-side bus bridge between the MiniMIPS32 core's data port (dce/daddr/we/din/dm) and the platform's data slaves.
- Decodes each access to either the synchronous data RAM or an internal MMIO register bank: LED output, synchronised switch input, 32-bit timer with compare interrupt.
- Preserves the core's one-cycle load latency for both targets.
- Parametrised in RAM depth, MMIO base, GPIO widths and synchroniser depth.

---
 rtl/dbus_mmio_bridge.sv | 130 +++++++++++++
 tb/tb_dbus_mmio_bridge.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbus_mmio_bridge.sv
// Data-side bridge for the MiniMIPS32 core: decodes each access to the synchronous
// data RAM or an internal MMIO bank (LED, synchronised switches, compare timer).
module dbus_mmio_bridge #(
  parameter int unsigned RAM_AW      = 11,
  parameter logic [15:0] MMIO_HI     = 16'hBFAF,
  parameter int unsigned LED_W       = 16,
  parameter int unsigned SW_W        = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              cpu_clk_50M,
  input  logic              cpu_rst,
  input  logic              dce,
  input  logic [31:0]       daddr,
  input  logic [3:0]        we,
  input  logic [31:0]       din,
  output logic [31:0]       dm,
  output logic              ram_ena,
  output logic [3:0]        ram_wea,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout,
  input  logic [SW_W-1:0]   sw_in,
  output logic [LED_W-1:0]  led_out,
  output logic              timer_irq
);

  typedef enum logic [5:0] {
    REG_LED    = 6'h00,
    REG_SW     = 6'h01,
    REG_COUNT  = 6'h02,
    REG_CMP    = 6'h03,
    REG_STATUS = 6'h04,
    REG_CTRL   = 6'h05
  } reg_off_e;

  logic             is_mmio;
  logic             mmio_wr;
  reg_off_e         reg_off;
  logic [31:0]      wmask;
  logic [31:0]      rd_val;
  logic [LED_W-1:0] led_next;
  logic [31:0]      count_next;
  logic [31:0]      cmp_next;

  logic [LED_W-1:0] led_q;
  logic [31:0]      count_q;
  logic [31:0]      cmp_q;
  logic             irq_pend;
  logic             timer_en;
  logic             irq_en;
  logic             sel_q;
  logic [31:0]      mmio_rd_q;
  logic [SW_W-1:0]  sync_q [SYNC_STAGES];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{daddr[15:8], daddr[1:0]};

  assign is_mmio  = dce & (daddr[31:16] == MMIO_HI);
  assign ram_ena  = dce & ~is_mmio;
  assign ram_wea  = ram_ena ? we : '0;
  assign ram_addr = daddr[RAM_AW+1:2];
  assign ram_din  = din;

  assign mmio_wr  = is_mmio & (|we);
  assign reg_off  = reg_off_e'(daddr[7:2]);
  assign wmask    = {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};

  assign dm        = sel_q ? mmio_rd_q : ram_dout;
  assign led_out   = led_q;
  assign timer_irq = irq_pend & irq_en;

  always_comb begin
    count_next = (count_q & ~wmask) | (din & wmask);
    cmp_next   = (cmp_q & ~wmask) | (din & wmask);
    led_next   = led_q;
    for (int unsigned i = 0; i < LED_W; i++) begin
      if (wmask[i]) led_next[i] = din[i];
    end
  end

  always_comb begin
    rd_val = '0;
    case (reg_off)
      REG_LED:    rd_val[LED_W-1:0] = led_q;
      REG_SW:     rd_val[SW_W-1:0]  = sync_q[SYNC_STAGES-1];
      REG_COUNT:  rd_val            = count_q;
      REG_CMP:    rd_val            = cmp_q;
      REG_STATUS: rd_val[0]         = irq_pend;
      REG_CTRL:   rd_val[1:0]       = {irq_en, timer_en};
      default:    rd_val            = '0;
    endcase
  end

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      led_q     <= '0;
      count_q   <= '0;
      cmp_q     <= '1;
      irq_pend  <= 1'b0;
      timer_en  <= 1'b0;
      irq_en    <= 1'b0;
      sel_q     <= 1'b0;
      mmio_rd_q <= '0;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= sw_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];

      // Read data is captured pre-write so dm shows the value the access observed.
      if (dce) begin
        sel_q     <= is_mmio;
        mmio_rd_q <= rd_val;
      end

      if (mmio_wr && reg_off == REG_LED) led_q <= led_next;
      if (mmio_wr && reg_off == REG_CMP) cmp_q <= cmp_next;
      if (mmio_wr && reg_off == REG_CTRL && we[0]) {irq_en, timer_en} <= din[1:0];

      // A COUNT write replaces the increment; unwritten bytes keep the old value.
      if (mmio_wr && reg_off == REG_COUNT) count_q <= count_next;
      else if (timer_en)                   count_q <= count_q + 32'd1;

      if (timer_en && count_q == cmp_q)
        irq_pend <= 1'b1;
      else if (mmio_wr && reg_off == REG_STATUS && we[0] && din[0])
        irq_pend <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dbus_mmio_bridge.sv
// Bench for dbus_mmio_bridge: directed scenarios plus randomized traffic compared
// every cycle against a transaction-level model of the bridge and its RAM.
module tb_dbus_mmio_bridge;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        dce = 1'b0;
  logic [31:0] daddr = '0;
  logic [3:0]  we = '0;
  logic [31:0] din = '0;
  logic [31:0] dm;
  logic        ram_ena;
  logic [3:0]  ram_wea;
  logic [10:0] ram_addr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout = '0;
  logic [15:0] sw_in = '0;
  logic [15:0] led_out;
  logic        timer_irq;

  dbus_mmio_bridge #(
    .RAM_AW(11), .MMIO_HI(16'hBFAF), .LED_W(16), .SW_W(16), .SYNC_STAGES(2)
  ) dut (
    .cpu_clk_50M(clk), .cpu_rst(rst), .dce(dce), .daddr(daddr), .we(we), .din(din),
    .dm(dm), .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout), .sw_in(sw_in), .led_out(led_out),
    .timer_irq(timer_irq)
  );

  // Synchronous read-first data RAM attached to the bridge.
  logic [31:0] ram [2048] = '{default: '0};
  always @(posedge clk) begin
    if (ram_ena) begin
      ram_dout <= ram[ram_addr];
      for (int b = 0; b < 4; b++)
        if (ram_wea[b]) ram[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model state
  logic [31:0] m_mem [2048] = '{default: '0};
  logic [31:0] m_last_ram = '0;
  logic        m_sel = 1'b0;
  logic [31:0] m_rd = '0;
  logic [15:0] m_led = '0;
  logic [31:0] m_count = '0;
  logic [31:0] m_cmp = '1;
  logic        m_pend = 1'b0, m_ten = 1'b0, m_ien = 1'b0;
  logic [15:0] swq [$];

  logic        chk_on = 1'b0;
  logic        e_ena, e_irq;
  logic [3:0]  e_wea;
  logic [10:0] e_addr;
  logic [31:0] e_din, e_dm;
  logic [15:0] e_led;

  function automatic logic [31:0] bmerge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] w);
    for (int b = 0; b < 4; b++) if (w[b]) old[8*b +: 8] = d[8*b +: 8];
    return old;
  endfunction

  function automatic logic [31:0] reg_read(input logic [7:0] off);
    logic [31:0] v;
    case (off & 8'hFC)
      8'h00:   v = {16'h0, m_led};
      8'h04:   v = (swq.size() == 2) ? {16'h0, swq[0]} : 32'h0;
      8'h08:   v = m_count;
      8'h0C:   v = m_cmp;
      8'h10:   v = {31'h0, m_pend};
      8'h14:   v = {30'h0, m_ien, m_ten};
      default: v = 32'h0;
    endcase
    return v;
  endfunction

  task automatic model_step();
    logic        mm, set, clr;
    logic [31:0] rd, nxt_count, tmp;
    logic [7:0]  off;
    logic [10:0] idx;
    mm  = dce && daddr[31:16] == 16'hBFAF;
    off = daddr[7:0] & 8'hFC;
    rd  = reg_read(daddr[7:0]);
    if (dce && !mm) begin
      idx = daddr[12:2];
      m_last_ram = m_mem[idx];
      m_mem[idx] = bmerge(m_mem[idx], din, we);
    end
    if (rst) begin
      m_led = '0; m_count = '0; m_cmp = '1; m_pend = 0; m_ten = 0; m_ien = 0;
      m_sel = 0; m_rd = '0; swq.delete();
    end else begin
      nxt_count = m_ten ? m_count + 1 : m_count;
      set = m_ten && (m_count == m_cmp);
      clr = 0;
      if (mm && we != 0) begin
        case (off)
          8'h00: begin tmp = bmerge({16'h0, m_led}, din, we); m_led = tmp[15:0]; end
          8'h08: nxt_count = bmerge(m_count, din, we);
          8'h0C: m_cmp = bmerge(m_cmp, din, we);
          8'h10: clr = we[0] & din[0];
          8'h14: if (we[0]) {m_ien, m_ten} = din[1:0];
          default: ;
        endcase
      end
      m_pend  = set ? 1'b1 : (clr ? 1'b0 : m_pend);
      m_count = nxt_count;
      if (dce) begin m_sel = mm; m_rd = rd; end
      swq.push_back(sw_in);
      if (swq.size() > 2) void'(swq.pop_front());
    end
  endtask

  task automatic drive(input logic r, input logic c, input logic [31:0] a,
                       input logic [3:0] w, input logic [31:0] d);
    logic mm;
    rst = r; dce = c; daddr = a; we = w; din = d;
    mm     = c && a[31:16] == 16'hBFAF;
    e_ena  = c && !mm;
    e_wea  = e_ena ? w : 4'h0;
    e_addr = a[12:2];
    e_din  = d;
    e_dm   = m_sel ? m_rd : m_last_ram;
    e_led  = m_led;
    e_irq  = m_pend & m_ien;
    @(posedge clk);
    model_step();
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("ram_ena",   32'(ram_ena),   32'(e_ena));
      chk("ram_wea",   32'(ram_wea),   32'(e_wea));
      chk("ram_addr",  32'(ram_addr),  32'(e_addr));
      chk("ram_din",   ram_din,        e_din);
      chk("dm",        dm,             e_dm);
      chk("led_out",   32'(led_out),   32'(e_led));
      chk("timer_irq", 32'(timer_irq), 32'(e_irq));
    end
  end

  localparam logic [31:0] LED_A = 32'hBFAF_0000, SW_A = 32'hBFAF_0004,
                          CNT_A = 32'hBFAF_0008, CMP_A = 32'hBFAF_000C,
                          ST_A  = 32'hBFAF_0010, CTL_A = 32'hBFAF_0014;

  initial begin
    logic        r, c;
    logic [31:0] a, d;
    logic [3:0]  w;
    logic [15:0] hi;
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    chk_on = 1'b1;
    drive(0, 0, 0, 0, 0);
    chk("rst_led", 32'(led_out), 32'h0);
    chk("rst_irq", 32'(timer_irq), 32'h0);

    drive(0, 1, 32'h10, 4'hF, 32'hDEADBEEF);
    drive(0, 1, 32'h10, 4'h0, 0);
    chk("ram_rd", dm, 32'hDEADBEEF);

    drive(0, 1, LED_A, 4'b0001, 32'h1234_56A5);
    chk("led_wr", 32'(led_out), 32'h00A5);
    drive(0, 1, LED_A, 4'h0, 0);
    chk("led_rd", dm, 32'h0000_00A5);

    sw_in = 16'h5A5A;
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 1, SW_A, 4'h0, 0);
    chk("sw_rd", dm, 32'h0000_5A5A);
    sw_in = 16'hA5A5;
    drive(0, 0, 0, 0, 0);
    drive(0, 1, SW_A, 4'h0, 0);
    chk("sw_old", dm, 32'h0000_5A5A);

    drive(0, 1, CMP_A, 4'hF, 5);
    drive(0, 1, CTL_A, 4'hF, 3);
    drive(0, 1, CNT_A, 4'hF, 0);
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 0);
    chk("irq_early", 32'(timer_irq), 32'h0);
    drive(0, 0, 0, 0, 0);
    chk("irq_rise", 32'(timer_irq), 32'h1);
    drive(0, 1, ST_A, 4'hF, 1);
    chk("irq_w1c", 32'(timer_irq), 32'h0);
    drive(0, 1, CNT_A, 4'hF, 5);
    drive(0, 0, 0, 0, 0);
    drive(0, 1, CTL_A, 4'hF, 1);
    chk("irq_masked", 32'(timer_irq), 32'h0);
    drive(0, 1, ST_A, 4'h0, 0);
    chk("status_pend", dm, 32'h1);

    drive(0, 1, CNT_A, 4'hF, 32'hFFFF_FFFE);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 1, CNT_A, 4'h0, 0);
    chk("count_wrap", dm, 32'h0);
    drive(0, 1, CNT_A, 4'hF, 32'h1234_56FF);
    drive(0, 1, CNT_A, 4'b0010, 32'h0000_AB00);
    drive(0, 1, CNT_A, 4'h0, 0);
    chk("count_bytewr", dm, 32'h1234_ABFF);

    drive(0, 1, 32'h20, 4'hF, 32'h1111_2222);
    drive(0, 1, LED_A, 4'hF, 32'h0000_CAFE);
    drive(0, 1, 32'h10, 4'h0, 0);
    chk("il_ram1", dm, 32'hDEADBEEF);
    drive(0, 1, LED_A, 4'h0, 0);
    chk("il_led", dm, 32'h0000_CAFE);
    drive(0, 1, 32'h20, 4'h0, 0);
    chk("il_ram2", dm, 32'h1111_2222);
    drive(0, 1, LED_A, 4'h0, 0);
    drive(1, 0, 0, 0, 0);
    chk("rst_dm", dm, 32'h1111_2222);
    chk("rst_led2", 32'(led_out), 32'h0);
    chk("rst_irq2", 32'(timer_irq), 32'h0);
    drive(0, 1, CMP_A, 4'h0, 0);
    chk("rst_cmp", dm, 32'hFFFF_FFFF);

    for (int n = 0; n < 3000; n++) begin
      r = ($urandom_range(0, 99) == 0);
      c = ($urandom_range(0, 9) < 8);
      if ($urandom_range(0, 1) == 1) begin
        if ($urandom_range(0, 9) < 8)
          a = {16'hBFAF, 8'($urandom), 3'b000, 3'($urandom), 2'($urandom)};
        else
          a = {16'hBFAF, 16'($urandom)};
      end else begin
        hi = 16'($urandom);
        if (hi == 16'hBFAF) hi = 16'h0;
        a = {hi, 3'($urandom), 7'b0, 4'($urandom), 2'($urandom)};
      end
      w = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom);
      case ($urandom_range(0, 2))
        0:       d = 32'($urandom_range(0, 15));
        1:       d = $urandom;
        default: d = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      endcase
      if ($urandom_range(0, 19) == 0) sw_in = 16'($urandom);
      drive(r, c, a, w, d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
